// File: rtl/cpu_bus_ram.sv
// RAM slave for the 6502-style CPU bus: address window, wait-state handshake,
// vector overlay at $FFFA-$FFFF and open-bus reads. Optional macro CPU_BUS_RAM_WP_EN adds write protect.
module cpu_bus_ram #(
  parameter int                ADDR_W      = 16,
  parameter int                DATA_W      = 8,
  parameter int                DEPTH_LOG2  = 11,
  parameter logic [ADDR_W-1:0] BASE        = '0,
  parameter int                WAIT_STATES = 0,
  parameter bit                VEC_EN      = 1'b1,
  parameter logic [15:0]       NMI_VEC     = 16'h0000,
  parameter logic [15:0]       RESET_VEC   = 16'h0000,
  parameter logic [15:0]       IRQ_VEC     = 16'h0001
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_oe,
  output logic              rdy,
  output logic              busy,
  output logic              hit
`ifdef CPU_BUS_RAM_WP_EN
  ,
  input  logic              wp,
  output logic              wp_err
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam logic [3:0]        WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [ADDR_W-1:0] VEC_HI  = ADDR_W'(16'hFFFF);

  state_t            state, state_nxt;
  logic [3:0]        wait_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] ob_q;
  logic              rw_q, vec_q, wp_q;
  logic              accept, enter_resp, commit;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata, a_rd_val;
  logic              a_rw, a_vec, a_hit;

  logic [DATA_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];

  function automatic logic addr_is_vec(input logic [ADDR_W-1:0] a);
    return VEC_EN && (a[ADDR_W-1:3] == VEC_HI[ADDR_W-1:3]) && (a[2] || a[1]);
  endfunction

  function automatic logic addr_in_win(input logic [ADDR_W-1:0] a);
    return (a >> DEPTH_LOG2) == (BASE >> DEPTH_LOG2);
  endfunction

  function automatic logic [DATA_W-1:0] vec_byte(input logic [ADDR_W-1:0] a);
    logic [15:0] v;
    case (a[2:1])
      2'b01:   v = NMI_VEC;
      2'b10:   v = RESET_VEC;
      default: v = IRQ_VEC;
    endcase
    return DATA_W'(a[0] ? v[15:8] : v[7:0]);
  endfunction

  // The access being decoded: live bus inputs on the accept edge, latched copy afterwards,
  // so zero-wait reads can load rdata on the same edge that accepts them.
  always_comb begin
    accept   = (state == S_IDLE) && req;
    a_addr   = accept ? addr  : addr_q;
    a_rw     = accept ? rw    : rw_q;
    a_wdata  = accept ? wdata : wdata_q;
    a_vec    = addr_is_vec(a_addr);
    a_hit    = a_vec || addr_in_win(a_addr);
    a_rd_val = a_vec ? vec_byte(a_addr) : mem[a_addr[DEPTH_LOG2-1:0]];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (req) state_nxt = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
      S_WAIT:  if (wait_cnt == 4'd0) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    enter_resp = (state_nxt == S_RESP);
  end

  always_comb begin
    rdy      = (state == S_RESP);
    busy     = (state != S_IDLE);
    rdata_oe = (state == S_RESP) && rw_q && hit;
`ifdef CPU_BUS_RAM_WP_EN
    wp_err   = (state == S_RESP) && !rw_q && hit && wp_q;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= 4'd0;
      rw_q     <= 1'b0;
      vec_q    <= 1'b0;
      hit      <= 1'b0;
      rdata    <= '0;
      ob_q     <= '0;
    end else begin
      if (accept) begin
        rw_q     <= rw;
        vec_q    <= a_vec;
        hit      <= a_hit;
        wait_cnt <= WS_LOAD;
      end else if (state == S_WAIT && wait_cnt != 4'd0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      // Open-bus latch tracks the last value seen on the bus; a read miss replays it.
      if (enter_resp) begin
        if (a_rw) begin
          rdata <= a_hit ? a_rd_val : ob_q;
          if (a_hit) ob_q <= a_rd_val;
        end else begin
          ob_q <= a_wdata;
        end
      end
    end
  end

`ifdef CPU_BUS_RAM_WP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       wp_q <= 1'b0;
    else if (accept) wp_q <= wp;
  end
`else
  assign wp_q = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= addr;
      wdata_q <= wdata;
    end
  end

  // Commit on the edge leaving RESP; an async reset before then drops the write.
  assign commit = (state == S_RESP) && !rw_q && hit && !vec_q && !wp_q;

  always_ff @(posedge clk) begin
    if (commit) mem[addr_q[DEPTH_LOG2-1:0]] <= wdata_q;
  end

endmodule

// File: tb/tb_cpu_bus_ram.sv
// Self-checking bench for cpu_bus_ram: a zero-wait and a three-wait instance driven
// with directed and random accesses against a behavioural bus model.
module tb_cpu_bus_ram;
  localparam int          WS0 = 0;
  localparam int          WS1 = 3;
  localparam logic [15:0] NMI = 16'hA1B2;
  localparam logic [15:0] RST = 16'hC3D4;
  localparam logic [15:0] IRQ = 16'h0001;

  logic        clk = 1'b0;
  logic        reset;
  logic        req [2];
  logic        rw [2];
  logic [15:0] addr [2];
  logic [7:0]  wdata [2];
  logic [7:0]  rdata [2];
  logic        rdata_oe [2];
  logic        rdy [2];
  logic        busy [2];
  logic        hit [2];
`ifdef CPU_BUS_RAM_WP_EN
  logic        wp [2];
  logic        wp_err [2];
`endif

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] mdl [2][2048];
  logic [7:0] ob [2];
  logic [7:0] last_rd [2];

  always #5 clk = ~clk;

  cpu_bus_ram #(.ADDR_W(16), .DATA_W(8), .DEPTH_LOG2(11), .BASE(16'h0000), .WAIT_STATES(WS0),
                .VEC_EN(1'b1), .NMI_VEC(NMI), .RESET_VEC(RST), .IRQ_VEC(IRQ)) u_ws0 (
    .clk(clk), .reset(reset), .req(req[0]), .rw(rw[0]), .addr(addr[0]), .wdata(wdata[0]),
    .rdata(rdata[0]), .rdata_oe(rdata_oe[0]), .rdy(rdy[0]), .busy(busy[0]), .hit(hit[0])
`ifdef CPU_BUS_RAM_WP_EN
    , .wp(wp[0]), .wp_err(wp_err[0])
`endif
  );

  cpu_bus_ram #(.ADDR_W(16), .DATA_W(8), .DEPTH_LOG2(11), .BASE(16'h0000), .WAIT_STATES(WS1),
                .VEC_EN(1'b1), .NMI_VEC(NMI), .RESET_VEC(RST), .IRQ_VEC(IRQ)) u_ws3 (
    .clk(clk), .reset(reset), .req(req[1]), .rw(rw[1]), .addr(addr[1]), .wdata(wdata[1]),
    .rdata(rdata[1]), .rdata_oe(rdata_oe[1]), .rdy(rdy[1]), .busy(busy[1]), .hit(hit[1])
`ifdef CPU_BUS_RAM_WP_EN
    , .wp(wp[1]), .wp_err(wp_err[1])
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] vec_val(input logic [15:0] a);
    logic [15:0] v;
    if (a < 16'hFFFC)      v = NMI;
    else if (a < 16'hFFFE) v = RST;
    else                   v = IRQ;
    return (a % 2 == 1) ? v[15:8] : v[7:0];
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      ob[d]      = 8'h00;
      last_rd[d] = 8'h00;
    end
  endtask

  // One complete bus access with model update and response checks.
  task automatic access(input int d, input bit r, input logic [15:0] a, input logic [7:0] wd,
                        input bit noise, input bit wpv);
    bit         vec, inwin, h;
    logic [7:0] v;
    int         lat, ws;
    string      t;
    ws    = (d == 0) ? WS0 : WS1;
    vec   = (a >= 16'hFFFA);
    inwin = (a < 16'h0800);
    h     = vec || inwin;
    v     = 8'h00;
    t     = $sformatf("d%0d %s %h", d, r ? "rd" : "wr", a);
    if (r) begin
      v = vec ? vec_val(a) : (inwin ? mdl[d][a[10:0]] : ob[d]);
      if (h) ob[d] = v;
      last_rd[d] = v;
    end else begin
      if (inwin && !wpv) mdl[d][a[10:0]] = wd;
      ob[d] = wd;
    end
    @(negedge clk);
    req[d] = 1'b1; rw[d] = r; addr[d] = a; wdata[d] = wd;
`ifdef CPU_BUS_RAM_WP_EN
    wp[d] = wpv;
`endif
    @(posedge clk);
    #1;
    req[d] = 1'b0;
    if (noise) begin
      rw[d] = 1'b0; addr[d] = a ^ 16'h0001; wdata[d] = ~wd;
    end
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (noise && !rdy[d]) req[d] = 1'b1;
    end while (!rdy[d] && lat < 40);
    req[d] = 1'b0;
    chk({t, " latency"}, lat, ws + 1);
    chk({t, " hit"}, hit[d], h);
    chk({t, " oe"}, rdata_oe[d], r && h);
    chk({t, " busy"}, busy[d], 1'b1);
    if (r) chk({t, " rdata"}, rdata[d], v);
`ifdef CPU_BUS_RAM_WP_EN
    chk({t, " wp_err"}, wp_err[d], wpv && !r && h);
    wp[d] = 1'b0;
`endif
    @(negedge clk);
    chk({t, " rdy_single"}, rdy[d], 1'b0);
    chk({t, " idle_after"}, busy[d], 1'b0);
    chk({t, " rdata_hold"}, rdata[d], last_rd[d]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a;
    logic [7:0]  wd;
    int          d, kind;
    bit          r;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; rw[i] = 1'b1; addr[i] = 16'h0; wdata[i] = 8'h0;
`ifdef CPU_BUS_RAM_WP_EN
      wp[i] = 1'b0;
`endif
    end
    model_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("d%0d reset rdy", i), rdy[i], 1'b0);
      chk($sformatf("d%0d reset busy", i), busy[i], 1'b0);
      chk($sformatf("d%0d reset rdata", i), rdata[i], 8'h00);
      chk($sformatf("d%0d reset oe", i), rdata_oe[i], 1'b0);
      chk($sformatf("d%0d reset hit", i), hit[i], 1'b0);
    end

    // Known contents for the low region of both RAMs; never $55 so the abort test discriminates.
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 64; k++) begin
        wd = 8'($urandom_range(0, 255));
        if (wd == 8'h55) wd = 8'h56;
        access(i, 1'b0, 16'(k), wd, 1'b0, 1'b0);
      end

    access(0, 1'b0, 16'h0012, 8'hA5, 1'b0, 1'b0);
    access(0, 1'b1, 16'h0012, 8'h00, 1'b0, 1'b0);
    access(0, 1'b1, 16'hFFFE, 8'h00, 1'b0, 1'b0);
    chk("irq_lo literal", rdata[0], 8'h01);
    access(0, 1'b1, 16'hFFFF, 8'h00, 1'b0, 1'b0);
    access(0, 1'b1, 16'hFFFA, 8'h00, 1'b0, 1'b0);
    access(0, 1'b1, 16'hFFFD, 8'h00, 1'b0, 1'b0);
    access(0, 1'b0, 16'hFFFE, 8'h77, 1'b0, 1'b0);
    access(0, 1'b1, 16'hFFFE, 8'h00, 1'b0, 1'b0);
    access(0, 1'b0, 16'h0005, 8'h3C, 1'b0, 1'b0);
    access(0, 1'b1, 16'h4000, 8'h00, 1'b0, 1'b0);
    chk("open_bus literal", rdata[0], 8'h3C);
    access(0, 1'b0, 16'h07FF, 8'h5A, 1'b0, 1'b0);
    access(0, 1'b1, 16'h07FF, 8'h00, 1'b0, 1'b0);
    access(0, 1'b1, 16'h0800, 8'h00, 1'b0, 1'b0);

    access(1, 1'b0, 16'h0100, 8'hE7, 1'b0, 1'b0);
    access(1, 1'b1, 16'h0100, 8'h00, 1'b1, 1'b0);
    access(1, 1'b0, 16'h0101, 8'h19, 1'b1, 1'b0);
    access(1, 1'b1, 16'h0100, 8'h00, 1'b0, 1'b0);

    // Abort a write while it waits; the RAM word must keep its old contents.
    @(negedge clk);
    req[1] = 1'b1; rw[1] = 1'b0; addr[1] = 16'h0020; wdata[1] = 8'h55;
    @(posedge clk);
    #1;
    req[1] = 1'b0;
    @(negedge clk);
    chk("abort in_wait", busy[1], 1'b1);
    reset = 1'b1;
    #1;
    chk("abort busy", busy[1], 1'b0);
    chk("abort rdy", rdy[1], 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("abort no_rdy", rdy[1], 1'b0);
    end
    access(1, 1'b1, 16'h0020, 8'h00, 1'b0, 1'b0);

`ifdef CPU_BUS_RAM_WP_EN
    access(0, 1'b0, 16'h0012, 8'h99, 1'b0, 1'b1);
    access(0, 1'b1, 16'h0012, 8'h00, 1'b0, 1'b1);
`endif

    for (int n = 0; n < 80; n++) begin
      d    = $urandom_range(0, 1);
      r    = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 5);
      wd   = 8'($urandom_range(0, 255));
      if (kind <= 2)      a = 16'($urandom_range(0, 63));
      else if (kind == 3) a = 16'($urandom_range(16'hFFFA, 16'hFFFF));
      else if (kind == 4) a = 16'($urandom_range(16'h0800, 16'hFFF9));
      else                a = 16'h07FF - 16'($urandom_range(0, 3));
      if (kind == 5 && r && d == 1) a = 16'h0020;
      access(d, r, a, wd, (d == 1) && ($urandom_range(0, 1) == 1), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
